// File: rtl/host_axi_pkg.sv
// Shared AXI4 response/burst encodings and the host-side driver state type,
// used by both the hostCtrl and hostMem AXI masters.
package host_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    HM_IDLE    = 3'd0,
    HM_WR_REQ  = 3'd1,
    HM_WR_RESP = 3'd2,
    HM_RD_REQ  = 3'd3,
    HM_RD_DATA = 3'd4,
    HM_RSP     = 3'd5
  } hm_state_e;

  // States in which the driver waits on the slave and is guarded by the timeout.
  function automatic logic is_phase_state(input hm_state_e s);
    case (s)
      HM_WR_REQ, HM_WR_RESP, HM_RD_REQ, HM_RD_DATA: is_phase_state = 1'b1;
      default:                                      is_phase_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/host_axi_timeout.sv
// Per-phase wait counter: cleared by load, counts enabled cycles and flags the
// last permitted cycle of a phase.
module host_axi_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Wait counter, saturating at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/host_ctrl_axi_master.sv
// Single-outstanding command/response to single-beat AXI4 master for the
// accelerator hostCtrl port; a phase timeout halts the block until reset.
module host_ctrl_axi_master
  import host_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_fault,
  output logic                  hung,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast
);

  localparam logic [2:0]          AXI_SIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [ID_WIDTH-1:0] AXI_ID_L = ID_WIDTH'(AXI_ID);

  hm_state_e             state_r;
  logic                  awvalid_r, wvalid_r, aw_done_r, w_done_r, bready_r;
  logic                  arvalid_r, rready_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic                  rsp_valid_r, rsp_fault_r, hung_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [1:0]            rsp_resp_r;

  logic cmd_ready_s, cmd_hs_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic phase_done_s, in_phase_s, tmo_load_s, tmo_expired_s, abort_s;
  logic b_bad_s, r_bad_s;

  assign cmd_ready_s = (state_r == HM_IDLE) && !hung_r;

  // Handshake decode and phase completion for the current state.
  always_comb begin
    cmd_hs_s = cmd_valid && cmd_ready_s;
    aw_hs_s  = awvalid_r && m_axi_awready;
    w_hs_s   = wvalid_r && m_axi_wready;
    b_hs_s   = bready_r && m_axi_bvalid;
    ar_hs_s  = arvalid_r && m_axi_arready;
    r_hs_s   = rready_r && m_axi_rvalid;
    case (state_r)
      HM_WR_REQ:  phase_done_s = (aw_done_r || aw_hs_s) && (w_done_r || w_hs_s);
      HM_WR_RESP: phase_done_s = b_hs_s;
      HM_RD_REQ:  phase_done_s = ar_hs_s;
      HM_RD_DATA: phase_done_s = r_hs_s;
      default:    phase_done_s = 1'b0;
    endcase
    in_phase_s = is_phase_state(state_r);
    tmo_load_s = !in_phase_s || phase_done_s;
    // A handshake landing on the expiry cycle still completes the phase.
    abort_s    = tmo_expired_s && !phase_done_s;
    b_bad_s    = (m_axi_bid != AXI_ID_L);
    r_bad_s    = (m_axi_rid != AXI_ID_L) || !m_axi_rlast;
  end

  host_axi_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load_s),
    .enable  (in_phase_s),
    .expired (tmo_expired_s)
  );

  // Command sequencing, AXI channel drivers and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= HM_IDLE;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wstrb_r     <= {STRB_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= AXI_RESP_OKAY;
      rsp_fault_r <= 1'b0;
      hung_r      <= 1'b0;
    end else if (abort_s) begin
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= AXI_RESP_SLVERR;
      rsp_fault_r <= 1'b1;
      hung_r      <= 1'b1;
      state_r     <= HM_RSP;
    end else begin
      case (state_r)
        HM_IDLE: begin
          if (cmd_hs_s) begin
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
            wstrb_r <= cmd_wstrb;
            if (cmd_write) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              state_r   <= HM_WR_REQ;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= HM_RD_REQ;
            end
          end
        end
        HM_WR_REQ: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (phase_done_s) begin
            bready_r <= 1'b1;
            state_r  <= HM_WR_RESP;
          end
        end
        HM_WR_RESP: begin
          if (b_hs_s) begin
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= b_bad_s ? AXI_RESP_SLVERR : m_axi_bresp;
            rsp_fault_r <= b_bad_s;
            state_r     <= HM_RSP;
          end
        end
        HM_RD_REQ: begin
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= HM_RD_DATA;
          end
        end
        HM_RD_DATA: begin
          if (r_hs_s) begin
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= m_axi_rdata;
            rsp_resp_r  <= r_bad_s ? AXI_RESP_SLVERR : m_axi_rresp;
            rsp_fault_r <= r_bad_s;
            state_r     <= HM_RSP;
          end
        end
        HM_RSP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= HM_IDLE;
          end
        end
        default: state_r <= HM_IDLE;
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_s;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign rsp_fault     = rsp_fault_r;
  assign hung          = hung_r;

  assign m_axi_awvalid = awvalid_r;
  assign m_axi_awid    = AXI_ID_L;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = bready_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_arid    = AXI_ID_L;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_host_ctrl_axi_master.sv
// Bench for host_ctrl_axi_master: table of directed transactions, randomized
// transactions against a behavioural model, and hand-written timeout/reset sequences.
module tb_host_ctrl_axi_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_fault, hung;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_awlock;
  logic [7:0]  m_axi_awid, m_axi_awlen;
  logic [15:0] m_axi_awaddr;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic [3:0]  m_axi_awcache;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_arlock;
  logic [7:0]  m_axi_arid, m_axi_arlen;
  logic [15:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  always #5 clk = ~clk;

  host_ctrl_axi_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8),
    .AXI_ID(0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_fault(rsp_fault), .hung(hung),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awid(m_axi_awid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    bit          hold_cmd;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic [7:0]  rid;
    logic [1:0]  rresp;
    bit          rlast;
    logic [31:0] rdata;
    logic [1:0]  exp_resp;
    bit          exp_fault;
    logic [31:0] exp_rdata;
    int          exp_lat;   // negative: timeout expected
  } vec_t;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  // Channel handshake counters.
  always @(posedge clk) begin
    if (m_axi_awvalid && m_axi_awready) aw_cnt <= aw_cnt + 1;
    if (m_axi_wvalid && m_axi_wready)   w_cnt  <= w_cnt + 1;
    if (m_axi_bvalid && m_axi_bready)   b_cnt  <= b_cnt + 1;
    if (m_axi_arvalid && m_axi_arready) ar_cnt <= ar_cnt + 1;
    if (m_axi_rvalid && m_axi_rready)   r_cnt  <= r_cnt + 1;
  end

  task automatic check(input int idx, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  function automatic vec_t mk_wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int aw_d, input int w_d, input int b_d,
                                 input logic [7:0] bid, input logic [1:0] bresp,
                                 input logic [1:0] er, input bit ef, input int el);
    vec_t v;
    v.write = 1'b1; v.addr = addr; v.wdata = data; v.wstrb = strb;
    v.aw_dly = aw_d; v.w_dly = w_d; v.b_dly = b_d; v.ar_dly = 0; v.r_dly = 0;
    v.rsp_dly = 0; v.hold_cmd = 1'b0;
    v.bid = bid; v.bresp = bresp; v.rid = 8'h00; v.rresp = 2'b00; v.rlast = 1'b1; v.rdata = 32'h0;
    v.exp_resp = er; v.exp_fault = ef; v.exp_rdata = 32'h0; v.exp_lat = el;
    return v;
  endfunction

  function automatic vec_t mk_rd(input logic [15:0] addr, input int ar_d, input int r_d,
                                 input logic [7:0] rid, input logic [1:0] rresp, input bit rlast,
                                 input logic [31:0] rdata, input logic [1:0] er, input bit ef,
                                 input logic [31:0] erd, input int el);
    vec_t v;
    v.write = 1'b0; v.addr = addr; v.wdata = 32'h0; v.wstrb = 4'h0;
    v.aw_dly = 0; v.w_dly = 0; v.b_dly = 0; v.ar_dly = ar_d; v.r_dly = r_d;
    v.rsp_dly = 0; v.hold_cmd = 1'b0;
    v.bid = 8'h00; v.bresp = 2'b00; v.rid = rid; v.rresp = rresp; v.rlast = rlast; v.rdata = rdata;
    v.exp_resp = er; v.exp_fault = ef; v.exp_rdata = erd; v.exp_lat = el;
    return v;
  endfunction

  // Behavioural model: response rules and zero-wait latency plus slave stalls.
  function automatic vec_t ref_model(input vec_t v);
    vec_t e;
    bit   bad;
    e = v;
    if (v.write) begin
      bad = (v.bid != 8'h00);
      e.exp_rdata = 32'h0;
      e.exp_lat = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
      e.exp_resp = bad ? 2'b10 : v.bresp;
    end else begin
      bad = (v.rid != 8'h00) || !v.rlast;
      e.exp_rdata = v.rdata;
      e.exp_lat = 3 + v.ar_dly + v.r_dly;
      e.exp_resp = bad ? 2'b10 : v.rresp;
    end
    e.exp_fault = bad;
    return e;
  endfunction

  task automatic slave_aw(input int idx, input vec_t v);
    int n = 0;
    while (!m_axi_awvalid && n < 100) begin @(negedge clk); n++; end
    check(idx, "awvalid", m_axi_awvalid, 1);
    if (!m_axi_awvalid) return;
    repeat (v.aw_dly) @(negedge clk);
    check(idx, "awaddr", m_axi_awaddr, v.addr);
    check(idx, "aw len/size/burst/id", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid},
          {8'd0, 3'd2, 2'b01, 8'd0});
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
  endtask

  task automatic slave_w(input int idx, input vec_t v);
    int n = 0;
    while (!m_axi_wvalid && n < 100) begin @(negedge clk); n++; end
    check(idx, "wvalid", m_axi_wvalid, 1);
    if (!m_axi_wvalid) return;
    repeat (v.w_dly) @(negedge clk);
    check(idx, "wdata/wstrb/wlast", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {v.wdata, v.wstrb, 1'b1});
    m_axi_wready = 1'b1;
    @(negedge clk);
    m_axi_wready = 1'b0;
  endtask

  task automatic slave_b(input int idx, input vec_t v);
    int n = 0;
    while (!m_axi_bready && n < 100) begin @(negedge clk); n++; end
    check(idx, "bready", m_axi_bready, 1);
    if (!m_axi_bready) return;
    repeat (v.b_dly) @(negedge clk);
    m_axi_bvalid = 1'b1; m_axi_bid = v.bid; m_axi_bresp = v.bresp;
    @(negedge clk);
    m_axi_bvalid = 1'b0; m_axi_bid = 8'h00; m_axi_bresp = 2'b00;
  endtask

  task automatic slave_ar(input int idx, input vec_t v);
    int n = 0;
    while (!m_axi_arvalid && n < 100) begin @(negedge clk); n++; end
    check(idx, "arvalid", m_axi_arvalid, 1);
    if (!m_axi_arvalid) return;
    repeat (v.ar_dly) @(negedge clk);
    check(idx, "araddr", m_axi_araddr, v.addr);
    check(idx, "ar len/size/burst/id", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid},
          {8'd0, 3'd2, 2'b01, 8'd0});
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
  endtask

  task automatic slave_r(input int idx, input vec_t v);
    int n = 0;
    if (v.r_dly < 0) return;
    while (!m_axi_rready && n < 100) begin @(negedge clk); n++; end
    check(idx, "rready", m_axi_rready, 1);
    if (!m_axi_rready) return;
    repeat (v.r_dly) @(negedge clk);
    m_axi_rvalid = 1'b1; m_axi_rid = v.rid; m_axi_rdata = v.rdata;
    m_axi_rresp = v.rresp; m_axi_rlast = v.rlast;
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rid = 8'h00; m_axi_rdata = 32'h0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
  endtask

  task automatic watch_rsp(input int idx, input vec_t v);
    int lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check(idx, "rsp_valid", rsp_valid, 1);
    if (!rsp_valid) return;
    if (v.exp_lat >= 0) begin
      check(idx, "latency", lat, v.exp_lat);
      check(idx, "rsp_rdata", rsp_rdata, v.exp_rdata);
    end else begin
      check(idx, "timeout latency in window", (lat >= TMO && lat <= TMO + 4), 1);
    end
    check(idx, "rsp_resp", rsp_resp, v.exp_resp);
    check(idx, "rsp_fault", rsp_fault, v.exp_fault);
    if (v.hold_cmd) cmd_valid = 1'b1;
    for (int k = 0; k < v.rsp_dly; k++) begin
      @(negedge clk);
      if (v.hold_cmd) begin
        check(idx, "held rsp fields", {rsp_valid, rsp_rdata, rsp_resp, rsp_fault},
              {1'b1, v.exp_rdata, v.exp_resp, v.exp_fault});
        check(idx, "held cmd_ready/awvalid/arvalid", {cmd_ready, m_axi_awvalid, m_axi_arvalid}, 3'b000);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check(idx, "rsp_valid drop", rsp_valid, 0);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int a0, w0, b0, ar0, r0;
    int n = 0;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check(idx, "cmd_ready", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    fork
      begin if (v.write) slave_aw(idx, v); end
      begin if (v.write) slave_w(idx, v); end
      begin if (v.write) slave_b(idx, v); end
      begin if (!v.write) slave_ar(idx, v); end
      begin if (!v.write) slave_r(idx, v); end
      watch_rsp(idx, v);
    join
    check(idx, "beat counts aw/w/b/ar/r",
          {8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0), 8'(ar_cnt - ar0), 8'(r_cnt - r0)},
          {8'(v.write), 8'(v.write), 8'(v.write), 8'(!v.write), 8'(!v.write && v.r_dly >= 0)});
  endtask

  task automatic check_reset_state(input int idx);
    check(idx, "reset valids/readies",
          {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b00000);
    check(idx, "reset rsp/hung", {rsp_valid, rsp_rdata, rsp_resp, rsp_fault, hung}, 37'h0);
    check(idx, "reset cmd_ready", cmd_ready, 1);
  endtask

  localparam int NDIR = 12;
  vec_t tbl[NDIR];
  vec_t v;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bid = 8'h0;
    m_axi_bresp = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rid = 8'h0;
    m_axi_rdata = 32'h0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;

    tbl[0]  = mk_wr(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 8'h00, 2'b00, 2'b00, 1'b0, 3);
    tbl[1]  = mk_rd(16'h0020, 0, 0, 8'h00, 2'b00, 1'b1, 32'h12345678, 2'b00, 1'b0, 32'h12345678, 3);
    tbl[2]  = mk_wr(16'h0030, 32'hA5A5A5A5, 4'h3, 5, 0, 0, 8'h00, 2'b00, 2'b00, 1'b0, 8);
    tbl[3]  = mk_wr(16'h0034, 32'h01020304, 4'hC, 0, 0, 2, 8'h00, 2'b00, 2'b00, 1'b0, 5);
    tbl[4]  = mk_wr(16'h0040, 32'h55AA55AA, 4'hF, 0, 0, 0, 8'h00, 2'b11, 2'b11, 1'b0, 3);
    tbl[5]  = mk_rd(16'h0044, 0, 0, 8'h05, 2'b00, 1'b1, 32'hCAFEF00D, 2'b10, 1'b1, 32'hCAFEF00D, 3);
    tbl[6]  = mk_rd(16'h0048, 0, 1, 8'h00, 2'b00, 1'b0, 32'h0BADF00D, 2'b10, 1'b1, 32'h0BADF00D, 4);
    tbl[7]  = mk_wr(16'h004C, 32'h11112222, 4'h1, 0, 0, 0, 8'h03, 2'b00, 2'b10, 1'b1, 3);
    tbl[8]  = mk_rd(16'h0050, 2, 3, 8'h00, 2'b01, 1'b1, 32'h87654321, 2'b01, 1'b0, 32'h87654321, 8);
    tbl[9]  = mk_rd(16'h0054, 0, 0, 8'h00, 2'b10, 1'b1, 32'h00000001, 2'b10, 1'b0, 32'h00000001, 3);
    tbl[10] = mk_wr(16'h0058, 32'hFFFF0000, 4'h6, 1, 4, 0, 8'h00, 2'b00, 2'b00, 1'b0, 7);
    tbl[11] = mk_rd(16'h005C, 0, 0, 8'h00, 2'b00, 1'b1, 32'h5A5A0F0F, 2'b00, 1'b0, 32'h5A5A0F0F, 3);
    tbl[11].rsp_dly = 10;
    tbl[11].hold_cmd = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_state(-1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NDIR; i++) run_txn(i, tbl[i]);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        v = mk_wr(16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                  2'($urandom_range(0, 3)), 2'b00, 1'b0, 0);
      else
        v = mk_rd(16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC, $urandom_range(0, 4),
                  $urandom_range(0, 4),
                  ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0), $urandom,
                  2'b00, 1'b0, 32'h0, 0);
      v.rsp_dly = $urandom_range(0, 3);
      run_txn(100 + i, ref_model(v));
    end

    // Read whose data never arrives: timeout, sticky hung, then reset recovery.
    v = mk_rd(16'h0060, 0, -1, 8'h00, 2'b00, 1'b1, 32'h0, 2'b10, 1'b1, 32'h0, -1);
    run_txn(200, v);
    check(200, "hung after timeout", hung, 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0064;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check(200, "cmd_ready/arvalid while hung", {cmd_ready, m_axi_arvalid, hung}, 3'b001);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_state(201);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(202, mk_rd(16'h0068, 1, 0, 8'h00, 2'b00, 1'b1, 32'h13572468, 2'b00, 1'b0, 32'h13572468, 4));

    // Reset asserted while AW/W are pending with no slave response.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0070; cmd_wdata = 32'h2468ACE0; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check(203, "aw/w pending before reset", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    rst = 1'b1;
    #1;
    check(203, "aw/w dropped by async reset", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(204);
    @(negedge clk);
    run_txn(205, mk_wr(16'h0074, 32'h0F1E2D3C, 4'hF, 0, 2, 1, 8'h00, 2'b00, 2'b00, 1'b0, 6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
